celery_attr_stepper: RTL and testbench

- Parametrised N-channel fixed-point attribute interpolator. Successor to the fixed S15.16, 7-attribute gradient scheme.
- Loads per-triangle start values and dx/dy gradients. Steps them across the pixel walk under command control: +x, -x (serpentine), next row.
- Emits one interpolated attribute vector per command.
- Sits between triangle setup and the fragment/perspective stage.

---
 rtl/celery_pkg.sv | 32 +++
 rtl/celery_attr_stepper_if.sv | 31 +++
 rtl/celery_attr_lane.sv | 64 ++++++
 rtl/celery_attr_stepper.sv | 87 ++++++++
 tb/tb_celery_attr_stepper.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/celery_pkg.sv
// Shared types and helpers for the celery attribute stepper.
// The fp_sat helper is only reached when CELERY_ATTR_SAT_EN is defined.
package celery_pkg;

  localparam int ATTR_GUARD_BITS = 4;

  typedef enum logic [1:0] {
    CMD_EMIT     = 2'd0,
    CMD_STEP_PX  = 2'd1,
    CMD_STEP_NX  = 2'd2,
    CMD_NEXT_ROW = 2'd3
  } attr_cmd_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } attr_state_e;

  // Clamp a sign-extended accumulator value to the signed fp_w range.
  // Callers keep fp_w <= 64.
  function automatic logic signed [63:0] fp_sat(input logic signed [63:0] v,
                                                input int fp_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (fp_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/celery_attr_stepper_if.sv
// Setup / command / output handshake bundle of the attribute stepper.
interface celery_attr_stepper_if #(
  parameter int NUM_ATTR = 7,
  parameter int FP_W     = 32
);
  logic                     setup_valid;
  logic                     setup_ready;
  logic [NUM_ATTR*FP_W-1:0] setup_start;
  logic [NUM_ATTR*FP_W-1:0] setup_dx;
  logic [NUM_ATTR*FP_W-1:0] setup_dy;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic                     cmd_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_ATTR*FP_W-1:0] out_attr;
  logic                     out_last;

  modport master (
    output setup_valid, setup_start, setup_dx, setup_dy,
    output cmd_valid, cmd_op, cmd_last, out_ready,
    input  setup_ready, cmd_ready, out_valid, out_attr, out_last
  );

  modport slave (
    input  setup_valid, setup_start, setup_dx, setup_dy,
    input  cmd_valid, cmd_op, cmd_last, out_ready,
    output setup_ready, cmd_ready, out_valid, out_attr, out_last
  );
endinterface

// File: rtl/celery_attr_lane.sv
// One attribute channel: row/cur accumulators, gradients, step mux and
// output register. Output saturates when CELERY_ATTR_SAT_EN is defined.
module celery_attr_lane
  import celery_pkg::*;
#(
  parameter int FP_W       = 32,
  parameter int GUARD_BITS = ATTR_GUARD_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  attr_cmd_e       op,
  input  logic [FP_W-1:0] start,
  input  logic [FP_W-1:0] dx,
  input  logic [FP_W-1:0] dy,
  output logic [FP_W-1:0] attr
);
  localparam int ACC_W = FP_W + GUARD_BITS;

  logic signed [ACC_W-1:0] row_acc, cur_acc, dx_r, dy_r;
  logic signed [ACC_W-1:0] row_nxt, cur_nxt;
  logic        [FP_W-1:0]  attr_d;

  always_comb begin
    row_nxt = row_acc;
    cur_nxt = cur_acc;
    case (op)
      CMD_STEP_PX: cur_nxt = cur_acc + dx_r;
      CMD_STEP_NX: cur_nxt = cur_acc - dx_r;
      CMD_NEXT_ROW: begin
        row_nxt = row_acc + dy_r;
        cur_nxt = row_nxt;
      end
      default: ;
    endcase
  end

`ifdef CELERY_ATTR_SAT_EN
  assign attr_d = FP_W'(fp_sat(64'(cur_nxt), FP_W));
`else
  assign attr_d = cur_nxt[FP_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      row_acc <= '0;
      cur_acc <= '0;
      dx_r    <= '0;
      dy_r    <= '0;
      attr    <= '0;
    end else if (load) begin
      row_acc <= ACC_W'(signed'(start));
      cur_acc <= ACC_W'(signed'(start));
      dx_r    <= ACC_W'(signed'(dx));
      dy_r    <= ACC_W'(signed'(dy));
    end else if (step) begin
      row_acc <= row_nxt;
      cur_acc <= cur_nxt;
      attr    <= attr_d;
    end
  end

endmodule

// File: rtl/celery_attr_stepper.sv
// N-channel fixed-point attribute stepper: IDLE/ACTIVE FSM and handshakes
// around NUM_ATTR celery_attr_lane instances. Optional macro CELERY_ATTR_SAT_EN.
module celery_attr_stepper
  import celery_pkg::*;
#(
  parameter int NUM_ATTR   = 7,
  parameter int FP_W       = 32,
  parameter int FRAC_BITS  = 16,
  parameter int GUARD_BITS = ATTR_GUARD_BITS
) (
  input logic            clk,
  input logic            rst,
  celery_attr_stepper_if.slave bus
);
  // Output word = integer part + fraction; saturation bounds span the whole word.
  localparam int OUT_W = (FP_W - FRAC_BITS) + FRAC_BITS;

  attr_state_e state_q, state_d;
  attr_cmd_e   op;
  logic        setup_rdy, cmd_rdy;
  logic        setup_fire, cmd_fire;
  logic        out_valid_q, out_last_q;
  logic [NUM_ATTR-1:0][FP_W-1:0] attr_q;

  assign op = attr_cmd_e'(bus.cmd_op);

  always_comb begin
    state_d   = state_q;
    setup_rdy = 1'b0;
    cmd_rdy   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        setup_rdy = 1'b1;
        if (bus.setup_valid) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        cmd_rdy = !out_valid_q || bus.out_ready;
        if (bus.cmd_valid && cmd_rdy && bus.cmd_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign setup_fire = setup_rdy && bus.setup_valid;
  assign cmd_fire   = cmd_rdy && bus.cmd_valid;

  // The last beat may still be stalled here after the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        out_valid_q <= 1'b1;
        out_last_q  <= bus.cmd_last;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_ATTR; g++) begin : g_lane
    celery_attr_lane #(
      .FP_W       (OUT_W),
      .GUARD_BITS (GUARD_BITS)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (setup_fire),
      .step  (cmd_fire),
      .op    (op),
      .start (bus.setup_start[g*FP_W +: FP_W]),
      .dx    (bus.setup_dx[g*FP_W +: FP_W]),
      .dy    (bus.setup_dy[g*FP_W +: FP_W]),
      .attr  (attr_q[g])
    );
  end

  assign bus.setup_ready = setup_rdy;
  assign bus.cmd_ready   = cmd_rdy;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_attr    = attr_q;

endmodule

// File: tb/tb_celery_attr_stepper.sv
// Bench for celery_attr_stepper: directed walk cases plus random traffic,
// checked against a position-based model (value = start + x*dx + y*dy).
module tb_celery_attr_stepper;
  localparam int NA = 3;
  localparam int FW = 32;
  localparam int GB = 4;
  localparam int AW = FW + GB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  celery_attr_stepper_if #(.NUM_ATTR(NA), .FP_W(FW)) bus ();

  celery_attr_stepper #(
    .NUM_ATTR(NA), .FP_W(FW), .FRAC_BITS(16), .GUARD_BITS(GB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: walk position plus per-triangle coefficients.
  bit               m_act, m_ov, m_last;
  logic [NA*FW-1:0] m_out;
  longint           m_st[NA], m_dx[NA], m_dy[NA];
  longint           ix, iy;

  function automatic logic [FW-1:0] fmt(input longint v);
    longint w;
    w = (v <<< (64 - AW)) >>> (64 - AW);
`ifdef CELERY_ATTR_SAT_EN
    if (w > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (w < -64'sd2147483648) return 32'h8000_0000;
`endif
    return w[FW-1:0];
  endfunction

  task automatic model_reset();
    m_act = 0; m_ov = 0; m_last = 0; m_out = '0;
  endtask

  // Inputs are set by the caller just after an edge; settle, check, advance.
  task automatic tick();
    bit cf, sf;
    #1;
    chk("setup_ready", bus.setup_ready, !m_act);
    chk("cmd_ready",   bus.cmd_ready,   m_act && (!m_ov || bus.out_ready));
    chk("out_valid",   bus.out_valid,   m_ov);
    chk("out_attr",    bus.out_attr,    m_out);
    chk("out_last",    bus.out_last,    m_last);
    if (rst) begin
      model_reset();
    end else begin
      cf = m_act && bus.cmd_valid && (!m_ov || bus.out_ready);
      sf = !m_act && bus.setup_valid;
      if (m_ov && bus.out_ready) m_ov = 0;
      if (sf) begin
        for (int i = 0; i < NA; i++) begin
          m_st[i] = longint'(signed'(bus.setup_start[i*FW +: FW]));
          m_dx[i] = longint'(signed'(bus.setup_dx[i*FW +: FW]));
          m_dy[i] = longint'(signed'(bus.setup_dy[i*FW +: FW]));
        end
        ix = 0; iy = 0; m_act = 1;
      end
      if (cf) begin
        case (bus.cmd_op)
          2'd1: ix++;
          2'd2: ix--;
          2'd3: begin iy++; ix = 0; end
          default: ;
        endcase
        for (int i = 0; i < NA; i++)
          m_out[i*FW +: FW] = fmt(m_st[i] + ix*m_dx[i] + iy*m_dy[i]);
        m_ov = 1;
        m_last = bus.cmd_last;
        if (bus.cmd_last) m_act = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_setup(input logic [31:0] s, input logic [31:0] d, input logic [31:0] y);
    for (int i = 0; i < NA; i++) begin
      bus.setup_start[i*FW +: FW] = s;
      bus.setup_dx[i*FW +: FW]    = d;
      bus.setup_dy[i*FW +: FW]    = y;
    end
    bus.setup_valid = 1'b1;
    tick();
    bus.setup_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic last);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_last  = last;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_last  = 1'b0;
  endtask

  task automatic chk0(input string tag, input logic [31:0] exp);
    chk({tag, "_valid"}, bus.out_valid, 1'b1);
    chk(tag, bus.out_attr[FW-1:0], exp);
  endtask

`ifdef CELERY_ATTR_SAT_EN
  localparam logic [31:0] OVF_P = 32'h7FFF_FFFF;
  localparam logic [31:0] OVF_N = 32'h8000_0000;
`else
  localparam logic [31:0] OVF_P = 32'h8001_0000;
  localparam logic [31:0] OVF_N = 32'h7FFF_0000;
`endif

  initial begin
    rst = 1'b1;
    bus.setup_valid = 0; bus.setup_start = '0; bus.setup_dx = '0; bus.setup_dy = '0;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_last = 0; bus.out_ready = 1;
    model_reset();
    @(posedge clk); #1;
    tick();
    rst = 1'b0;

    // basic stepping and row step
    do_setup(32'h0001_0000, 32'h0000_8000, 32'hFFFF_C000);
    send(2'd0, 0); chk0("basic_emit", 32'h0001_0000);
    send(2'd1, 0); chk0("basic_px1",  32'h0001_8000);
    send(2'd1, 0); chk0("basic_px2",  32'h0002_0000);
    send(2'd3, 0); chk0("row_next",   32'h0000_C000);
    send(2'd2, 0); chk0("row_nx",     32'h0000_4000);

    // backpressure: pending STEP_PX waits while the previous beat stalls
    send(2'd1, 0); chk0("bp_px", 32'h0000_C000);
    bus.out_ready = 0; bus.cmd_valid = 1; bus.cmd_op = 2'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold", bus.out_attr[FW-1:0], 32'h0000_C000);
    end
    bus.out_ready = 1;
    #1 chk("bp_release_ready", bus.cmd_ready, 1'b1);
    tick();
    bus.cmd_valid = 0;
    chk0("bp_after", 32'h0001_4000);
    send(2'd0, 1);
    tick();

    // overflow at the output word
    do_setup(32'h7FFF_0000, 32'h0002_0000, 32'h0);
    send(2'd1, 1); chk0("ovf_pos", OVF_P);
    tick();
    do_setup(32'h8001_0000, 32'h0002_0000, 32'h0);
    send(2'd2, 1); chk0("ovf_neg", OVF_N);
    tick();

    // last beat stalled while the next triangle loads
    do_setup(32'h0003_0000, 32'h0001_0000, 32'h0001_0000);
    send(2'd0, 1); chk0("last_beat", 32'h0003_0000);
    chk("last_flag", bus.out_last, 1'b1);
    bus.out_ready = 0;
    #1 chk("last_setup_ready", bus.setup_ready, 1'b1);
    do_setup(32'h0005_0000, 32'h0001_0000, 32'h0001_0000);
    chk("last_stall_attr", bus.out_attr[FW-1:0], 32'h0003_0000);
    chk("last_stall_flag", bus.out_last, 1'b1);
    bus.out_ready = 1;
    tick();
    send(2'd0, 0); chk0("reload_emit", 32'h0005_0000);

    // reset with a pending beat
    send(2'd1, 0);
    bus.out_ready = 0; rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_setup_ready", bus.setup_ready, 1'b1);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    bus.out_ready = 1;
    do_setup(32'h0007_0000, 32'h0000_1000, 32'h0000_2000);
    send(2'd0, 0); chk0("rst_fresh", 32'h0007_0000);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.setup_valid = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NA; i++) begin
        bus.setup_start[i*FW +: FW] = $urandom;
        bus.setup_dx[i*FW +: FW] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 32'h3FFFF)) - 32'h2_0000;
        bus.setup_dy[i*FW +: FW] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 32'h3FFFF)) - 32'h2_0000;
      end
      bus.cmd_valid = ($urandom_range(0, 9) < 7);
      bus.cmd_op    = 2'($urandom_range(0, 3));
      bus.cmd_last  = ($urandom_range(0, 9) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    rst = 0; bus.setup_valid = 0; bus.cmd_valid = 0; bus.cmd_last = 0; bus.out_ready = 1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
